// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32 core constants, fetch FSM encoding and instruction type codes
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
  typedef enum logic [2:0] {IT_R, IT_I, IT_S, IT_B, IT_U, IT_J} instr_type_t;
endpackage

// File: rtl/ifetch_stage_32bit.sv
// ifetch_stage_32bit: RV32 fetch stage with one outstanding request, one-entry output register and redirect flush
module ifetch_stage_32bit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  fetch_state_t state, state_nx;
  logic [31:0] pc;
  logic req_hs, load;
  assign imem_req_valid = rst_n & (state == S_REQ) & (!id_valid | id_ready) & !redirect_valid;
  assign imem_req_addr = pc;
  assign req_hs = imem_req_valid & imem_req_ready;
  assign load = (state == S_WAIT) & imem_rsp_valid & !redirect_valid;
  assign id_pc_plus4 = id_pc + 32'd4;
  // a response always closes the outstanding fetch, whether kept or dropped
  always_comb begin
    state_nx = state;
    state_nx = state == S_REQ ? (req_hs ? S_WAIT : S_REQ) :
               imem_rsp_valid ? S_REQ :
               redirect_valid ? S_DROP : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_REQ;
      pc <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc <= 32'd0;
    end else begin
      state <= state_nx;
      pc <= redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : req_hs ? pc + 32'd4 : pc;
      id_valid <= !redirect_valid & (load | (id_valid & !id_ready));
      if (load) begin
        id_instr <= imem_rsp_data;
        id_pc <= pc - 32'd4;
      end
    end
endmodule

// File: tb/tb_ifetch_stage_32bit.sv
// tb_ifetch_stage_32bit: randomized scoreboard bench with a fetch-stream reference model
module tb_ifetch_stage_32bit;
  import cpu_pkg::*;
  logic clk = 0, rst_n = 0;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic id_valid, id_ready = 0;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  always #5 clk = ~clk;

  ifetch_stage_32bit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;
  logic [31:0] exp_pc = RESET_PC_DEFAULT;
  int lat_min = 0, lat_max = 0;
  bit mem_busy = 0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 0, acc_addr = 0;
  bit acc_q = 0;
  bit prev_hold = 0, prev_redir = 0;
  logic [31:0] p_instr, p_pc, p_plus4;
  int idle = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction memory: one response per accepted request after a random delay
  always @(negedge clk) begin
    acc_q = rst_n && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
  end
  always @(posedge clk) begin
    #1;
    imem_rsp_valid = 0;
    if (acc_q) begin
      chk("one_outstanding", 32'(mem_busy), 32'd0);
      mem_busy = 1;
      mem_addr = acc_addr;
      mem_cnt = int'($urandom_range(lat_max, lat_min));
    end
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data = mem_word(mem_addr);
        mem_busy = 0;
      end else mem_cnt--;
    end
    if (!rst_n) begin
      mem_busy = 0;
      imem_rsp_valid = 0;
    end
  end

  // monitor: the model expects a sequential PC stream that restarts at each redirect target
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_pc = RESET_PC_DEFAULT;
      prev_hold = 0;
      prev_redir = 0;
      idle = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(id_valid), 32'd1);
        chk("hold_instr", id_instr, p_instr);
        chk("hold_pc", id_pc, p_pc);
        chk("hold_pc_plus4", id_pc_plus4, p_plus4);
      end
      if (prev_redir) chk("redirect_clears_valid", 32'(id_valid), 32'd0);
      if (id_valid && !id_ready) chk("stall_blocks_req", 32'(imem_req_valid), 32'd0);
      if (redirect_valid) chk("redirect_blocks_req", 32'(imem_req_valid), 32'd0);
      if (id_valid && id_ready) begin
        idle = 0;
        if (sb.size() == 0) chk("unexpected_instr_pc", id_pc, 32'hxxxx_xxxx);
        else begin
          e = sb.pop_front();
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          chk("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
        end
      end else if (++idle > 300) begin
        chk("progress_timeout", 32'(idle), 32'd0);
        idle = 0;
      end
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
      if (imem_req_valid && imem_req_ready) begin
        sb.push_back('{exp_pc, mem_word(exp_pc)});
        exp_pc += 32'd4;
      end
      if (redirect_valid) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
      prev_hold = id_valid && !id_ready && !redirect_valid;
      prev_redir = redirect_valid;
      p_instr = id_instr;
      p_pc = id_pc;
      p_plus4 = id_pc_plus4;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // mode 0: fetch outstanding with no response this cycle; 1: response this cycle; 2: id_valid
  task automatic wait_for(input int mode, input string name);
    bit hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc();
      hit = mode == 0 ? (mem_busy && !imem_rsp_valid) : mode == 1 ? imem_rsp_valid : id_valid;
    end
    if (!hit) chk(name, 32'd0, 32'd1);
  endtask

  task automatic check_reset();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, NOP_INSTR);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd4);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1;
    redirect_pc = target;
    cyc();
    redirect_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #3 check_reset();
    cyc();
    rst_n = 1;
    imem_req_ready = 1;
    id_ready = 1;
    repeat (12) cyc();
    wait_for(2, "stall_setup_timeout");
    id_ready = 0;
    repeat (5) cyc();
    id_ready = 1;
    repeat (6) cyc();
    lat_min = 3; lat_max = 3;
    wait_for(0, "redirect_wait_timeout");
    pulse_redirect(32'h0000_0100);
    lat_min = 0; lat_max = 0;
    repeat (10) cyc();
    wait_for(1, "redirect_rsp_timeout");
    pulse_redirect(32'h0000_0203);
    repeat (10) cyc();
    pulse_redirect(32'hFFFF_FFFC);
    repeat (10) cyc();
    for (int i = 0; i < 1500; i++) begin
      cyc();
      imem_req_ready = ($urandom % 4) != 0;
      id_ready = ($urandom % 4) != 0;
      lat_max = int'($urandom % 3);
      redirect_valid = !redirect_valid && ($urandom % 12) == 0;
      redirect_pc = ($urandom % 4) == 0 ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
    end
    redirect_valid = 0;
    imem_req_ready = 1;
    id_ready = 1;
    lat_min = 3; lat_max = 3;
    wait_for(0, "reset_wait_timeout");
    rst_n = 0;
    #1 check_reset();
    cyc();
    cyc();
    rst_n = 1;
    lat_min = 0; lat_max = 0;
    repeat (15) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
